// File: rtl/mem_wait_responder_pkg.sv
// Shared constants for the wait-state memory responder: FSM encoding, word width
// and the byte-address fault check.
package mem_wait_responder_pkg;

  localparam int WORD_W     = 32;
  localparam int BYTE_OFF_W = 2;
  localparam int CNT_W      = 4;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  // Misaligned byte address, or any set bit above the word-index field.
  function automatic logic addr_fault(input logic [WORD_W-1:0] a, input int addr_w);
    return (a[BYTE_OFF_W-1:0] != '0) || ((a >> (addr_w + BYTE_OFF_W)) != '0);
  endfunction

endpackage

// File: rtl/mem_wait_responder_ram.sv
// Single-port word RAM with write enable and registered read port; the read
// register only updates on enabled reads, so it holds its value otherwise.
module resp_word_ram
  import mem_wait_responder_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (en && we) begin
      mem[addr] <= wdata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdata <= '0;
    end else if (en && !we) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/mem_wait_responder.sv
// Memory-side responder: captures a word request, waits WAIT_CYCLES, then
// answers with a one-cycle ack, flagging misaligned or out-of-range addresses.
module mem_wait_responder
  import mem_wait_responder_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic              we,
  input  logic [WORD_W-1:0] addr,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata,
  output logic              ack,
  output logic              err,
  output logic              busy
);

  logic [1:0]        state_reg, state_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic              we_reg;
  logic [WORD_W-1:0] addr_reg, wdata_reg;
  logic              capture, enter_resp;
  logic              acc_we, acc_fault, ram_en;
  logic [WORD_W-1:0] acc_addr, acc_wdata;

  assign capture = (state_reg == S_IDLE) && req;

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    enter_resp = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (req) begin
          if (WAIT_CYCLES == 0) begin
            state_next = S_RESP;
            enter_resp = 1'b1;
          end else begin
            state_next = S_WAIT;
            cnt_next   = CNT_W'(WAIT_CYCLES);
          end
        end
      end
      S_WAIT: begin
        cnt_next = cnt_reg - 1'b1;
        if (cnt_reg == CNT_W'(1)) begin
          state_next = S_RESP;
          enter_resp = 1'b1;
        end
      end
      S_RESP:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // With zero wait states the access happens on the capture edge itself, so
  // the live inputs stand in for the not-yet-loaded holding registers.
  assign acc_we    = (state_reg == S_IDLE) ? we    : we_reg;
  assign acc_addr  = (state_reg == S_IDLE) ? addr  : addr_reg;
  assign acc_wdata = (state_reg == S_IDLE) ? wdata : wdata_reg;
  assign acc_fault = addr_fault(acc_addr, ADDR_W);
  assign ram_en    = enter_resp && !acc_fault;

  resp_word_ram #(.ADDR_W(ADDR_W)) u_ram (
    .clk   (clk),
    .reset (reset),
    .en    (ram_en),
    .we    (acc_we),
    .addr  (acc_addr[ADDR_W+BYTE_OFF_W-1:BYTE_OFF_W]),
    .wdata (acc_wdata),
    .rdata (rdata)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= S_IDLE;
      cnt_reg   <= '0;
      we_reg    <= 1'b0;
      addr_reg  <= '0;
      wdata_reg <= '0;
      ack       <= 1'b0;
      err       <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      if (capture) begin
        we_reg    <= we;
        addr_reg  <= addr;
        wdata_reg <= wdata;
      end
      ack <= enter_resp;
      err <= enter_resp && acc_fault;
    end
  end

  assign busy = (state_reg == S_WAIT) || (state_reg == S_RESP);

endmodule

// File: tb/tb_mem_wait_responder.sv
// Directed bench: one responder with two wait states and one with none, checked
// against hand-computed latencies, data and fault flags.
module tb_mem_wait_responder;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_a = 1'b0, req_b = 1'b0;
  logic        we = 1'b0;
  logic [31:0] addr = '0, wdata = '0;
  logic [31:0] rdata_a, rdata_b;
  logic        ack_a, ack_b, err_a, err_b, busy_a, busy_b;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_wait_responder #(.ADDR_W(8), .WAIT_CYCLES(2)) dut (
    .clk(clk), .reset(reset), .req(req_a), .we(we), .addr(addr), .wdata(wdata),
    .rdata(rdata_a), .ack(ack_a), .err(err_a), .busy(busy_a)
  );

  mem_wait_responder #(.ADDR_W(8), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .reset(reset), .req(req_b), .we(we), .addr(addr), .wdata(wdata),
    .rdata(rdata_b), .ack(ack_b), .err(err_b), .busy(busy_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One request on the selected DUT; lat counts sampled cycles from capture
  // through the ack cycle inclusive (-1 on timeout).
  task automatic access(input bit sel, input logic w, input logic [31:0] a,
                        input logic [31:0] d, output int lat,
                        output logic [31:0] rd, output logic e, output int bcnt);
    logic got;
    @(negedge clk);
    we = w; addr = a; wdata = d;
    if (sel) req_b = 1'b1; else req_a = 1'b1;
    @(posedge clk);
    #1;
    req_a = 1'b0; req_b = 1'b0;
    lat = -1; bcnt = 0; rd = '0; e = 1'b0; got = 1'b0;
    for (int i = 1; i <= 20 && !got; i++) begin
      @(negedge clk);
      if (sel ? busy_b : busy_a) bcnt++;
      if (sel ? ack_b : ack_a) begin
        lat = i; got = 1'b1;
        rd = sel ? rdata_b : rdata_a;
        e  = sel ? err_b : err_a;
      end
    end
    $display("txn dut=%0d we=%0b addr=%h wdata=%h lat=%0d rdata=%h err=%0b",
             sel, w, a, d, lat, rd, e);
  endtask

  // Hold a read request high and return the spacing of the first three acks.
  task automatic stream(input bit sel, output int gap1, output int gap2);
    int t[3];
    int n;
    n = 0; t[0] = -100; t[1] = -100; t[2] = -100;
    @(negedge clk);
    we = 1'b0; addr = 32'h10;
    if (sel) req_b = 1'b1; else req_a = 1'b1;
    for (int i = 0; i < 40 && n < 3; i++) begin
      @(negedge clk);
      if (sel ? ack_b : ack_a) begin
        t[n] = cyc; n++;
      end
    end
    req_a = 1'b0; req_b = 1'b0;
    @(negedge clk);
    gap1 = (n == 3) ? t[1] - t[0] : -1;
    gap2 = (n == 3) ? t[2] - t[1] : -1;
    $display("txn dut=%0d stream acks=%0d gaps=%0d,%0d", sel, n, gap1, gap2);
  endtask

  initial begin
    int lat, bcnt, g1, g2;
    logic [31:0] rd;
    logic e;

    repeat (2) @(negedge clk);
    chk("reset_rdata", rdata_a, 32'h0);
    chk("reset_ack", {31'b0, ack_a}, 32'h0);
    chk("reset_err", {31'b0, err_a}, 32'h0);
    chk("reset_busy", {31'b0, busy_a}, 32'h0);
    reset = 1'b0;

    access(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, lat, rd, e, bcnt);
    chk("wr10_latency", 32'(lat), 32'd3);
    chk("wr10_err", {31'b0, e}, 32'h0);
    chk("wr10_busy_cycles", 32'(bcnt), 32'd3);

    access(1'b0, 1'b0, 32'h10, 32'h0, lat, rd, e, bcnt);
    chk("rd10_data", rd, 32'hDEADBEEF);
    chk("rd10_err", {31'b0, e}, 32'h0);
    repeat (5) @(negedge clk);
    chk("rd10_hold", rdata_a, 32'hDEADBEEF);

    access(1'b0, 1'b0, 32'h12, 32'h0, lat, rd, e, bcnt);
    chk("rd12_err", {31'b0, e}, 32'h1);
    chk("rd12_rdata_kept", rd, 32'hDEADBEEF);
    chk("rd12_latency", 32'(lat), 32'd3);

    access(1'b0, 1'b1, 32'h0, 32'hA5A50000, lat, rd, e, bcnt);
    access(1'b0, 1'b0, 32'h10, 32'h0, lat, rd, e, bcnt);
    chk("rd10_intact", rd, 32'hDEADBEEF);

    access(1'b0, 1'b1, 32'h400, 32'h12345678, lat, rd, e, bcnt);
    chk("wr400_err", {31'b0, e}, 32'h1);
    access(1'b0, 1'b0, 32'h0, 32'h0, lat, rd, e, bcnt);
    chk("rd0_unchanged", rd, 32'hA5A50000);
    chk("rd0_err", {31'b0, e}, 32'h0);

    stream(1'b0, g1, g2);
    chk("stream2_gap1", 32'(g1), 32'd4);
    chk("stream2_gap2", 32'(g2), 32'd4);

    access(1'b1, 1'b1, 32'h10, 32'hCAFEF00D, lat, rd, e, bcnt);
    chk("w0_wr_latency", 32'(lat), 32'd1);
    access(1'b1, 1'b0, 32'h10, 32'h0, lat, rd, e, bcnt);
    chk("w0_rd_data", rd, 32'hCAFEF00D);
    chk("w0_rd_latency", 32'(lat), 32'd1);
    access(1'b1, 1'b0, 32'h3, 32'h0, lat, rd, e, bcnt);
    chk("w0_misaligned_err", {31'b0, e}, 32'h1);
    stream(1'b1, g1, g2);
    chk("stream0_gap1", 32'(g1), 32'd2);
    chk("stream0_gap2", 32'(g2), 32'd2);

    access(1'b0, 1'b1, 32'h20, 32'h1, lat, rd, e, bcnt);
    chk("wr20_err", {31'b0, e}, 32'h0);
    @(negedge clk);
    we = 1'b1; addr = 32'h20; wdata = 32'h2; req_a = 1'b1;
    @(posedge clk);
    #1 req_a = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("rst_wait_rdata", rdata_a, 32'h0);
    chk("rst_wait_ack", {31'b0, ack_a}, 32'h0);
    chk("rst_wait_err", {31'b0, err_a}, 32'h0);
    chk("rst_wait_busy", {31'b0, busy_a}, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    $display("txn dut=0 reset asserted during write wait");
    access(1'b0, 1'b0, 32'h20, 32'h0, lat, rd, e, bcnt);
    chk("rd20_after_reset", rd, 32'h1);
    chk("rd20_latency", 32'(lat), 32'd3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
